// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a simple dual-port RAM:
// pointers, RAM port sequencing, occupancy flags and a one-entry output stage.
module mor1kx_dpram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned PW        = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH   = PW'(1 << ADDR_WIDTH);
  localparam bit          BYPASS_EN = (USE_BYPASS != 0);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [PW-1:0] rcnt, rcnt_d;
  logic          push_ok, pop_ok, need, rd_ram, rd_byp;

  // Next-state: pointer advance, output-stage refill and registered flags
  always_comb begin
    push_ok     = push && !full_q && !flush;
    pop_ok      = pop && out_valid_q && !flush;
    need        = !out_valid_q || pop_ok;
    rcnt        = wptr_q - rptr_q;
    rd_ram      = need && (rcnt != '0) && !flush;
    // Empty RAM: read the address being written and let the RAM forward it
    rd_byp      = BYPASS_EN && need && (rcnt == '0) && push_ok;

    wptr_d      = wptr_q + PW'(push_ok);
    rptr_d      = rptr_q + PW'(rd_ram || rd_byp);
    out_valid_d = (rd_ram || rd_byp) ? 1'b1 : (out_valid_q && !pop_ok);
    overflow_d  = push && full_q && !flush;
    underflow_d = pop && !out_valid_q && !flush;

    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      out_valid_d = 1'b0;
    end

    rcnt_d  = wptr_d - rptr_d;
    full_d  = (rcnt_d == DEPTH);
    count_d = rcnt_d + PW'(out_valid_d);
  end

  // RAM port drive; held idle while reset is asserted
  always_comb begin
    ram_we    = push_ok && rst_n;
    ram_waddr = wptr_q[ADDR_WIDTH-1:0];
    ram_din   = push_data;
    ram_re    = (rd_ram || rd_byp) && rst_n;
    ram_raddr = rd_ram ? rptr_q[ADDR_WIDTH-1:0] : wptr_q[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign full      = full_q;
  assign valid     = out_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign pop_data  = ram_dout;

endmodule
